mopshub_elink_deframer: RTL and testbench
=========================================

# mopshub_elink_deframer

Receive-side deframer for the 2-bit elink stream that the MOPSHUB core drives towards the emulator/GBT end. It hunts byte alignment on a start-of-packet character, reassembles the 76-bit CAN frame word (the same layout as `data_tra_downlink`), checks the trailer, and presents the word through a one-deep valid/ack buffer. It sits in the emulator environment between `tx_elink2bit` and the downlink scoreboard, and is reusable as the uplink receiver inside the hub.

## Interface
Parameters:
- `SOP_CHAR`, 8'h3C, start-of-packet character.
- `EOP_CHAR`, 8'hDC, end-of-packet character.

Ports:
- `clk`  in  1  elink word clock; one dibit per rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `rx_elink2bit`  in  2  serial dibit; bit[1] is the earlier bit on the line.
- `data_out`  out  76  assembled frame word; held while `data_valid`.
- `data_valid`  out  1  frame available in the output buffer.
- `data_ack`  in  1  consumer accepts `data_out` this cycle.
- `frame_err`  out  1  one-cycle pulse: bad EOP or bad checksum.
- `overflow`  out  1  one-cycle pulse: good frame dropped, buffer full.
- `frame_cnt`  out  16  good frames delivered; wraps 16'hFFFF→0.
- `err_cnt`  out  8  `frame_err` + `overflow` events; saturates at 8'hFF.

## Operation
- Shift window: `win <= {win[5:0], rx_elink2bit}` every cycle. Bytes are MSB first.
- States: HUNT, DATA, CSUM, EOP.
- HUNT: `win` is compared to `SOP_CHAR` every cycle (all four dibit phases). On a match, go to DATA with dibit counter = 0 and byte counter = 0. No other character has any effect.
- DATA: every 4th dibit completes a byte. Ten bytes are received (80 bits). `data_out` = bits [75:0] of the 80-bit word; byte 0 is the MSB. The upper nibble of byte 0 is ignored. After byte 9 the FSM goes to CSUM (macro defined) or EOP.
- CSUM: one byte. It must equal the XOR of the ten data bytes. On a mismatch, pulse `frame_err`, increment `err_cnt`, and go to HUNT.
- EOP: one byte. It must equal `EOP_CHAR`. On a mismatch, pulse `frame_err` and go to HUNT. On a match the frame is good:
  - If the buffer is empty, or `data_ack` is high in the same cycle: load `data_out`, assert `data_valid`, and increment `frame_cnt`.
  - Otherwise: pulse `overflow`, increment `err_cnt`, and keep the old buffered word.
  - In both cases, return to HUNT.
- Buffer: `data_ack` while `data_valid` clears `data_valid` on the next edge. `data_ack` while the buffer is empty is ignored. If ack and load happen in the same cycle, the new word is loaded and `data_valid` stays 1.
- After every frame end the FSM re-enters HUNT. Back-to-back frames with no idle between them are legal: the next SOP may follow EOP immediately.
- `err_cnt` holds at 8'hFF once saturated. If two error events occur in one cycle, the counter increments once; this cannot occur by construction.

## Timing
- Reset (`rst`=0 at a rising edge) clears all state synchronously:
  - State = HUNT, `win` = 0.
  - `data_out` = 0, `data_valid` = 0, `frame_err` = 0, `overflow` = 0, `frame_cnt` = 0, `err_cnt` = 0.
  - Reset mid-frame discards the partial frame and raises no error.
- Latency: the edge that samples the last EOP dibit is edge N. `data_valid` (or `frame_err` / `overflow`) is high after edge N+1. All outputs are registered.
- SOP detection: the SOP's 4th dibit is sampled at edge M. The FSM is in DATA after edge M+1, and the next dibit (sampled at M+1) is data bit 79:78.
- Frame length: 4 (SOP) + 40 (data) + 4 (CSUM, if enabled) + 4 (EOP) cycles.
- `frame_err` and `overflow` are high for exactly one cycle per event.

## Configuration
- `ELINK_CHECKSUM_EN` defined:
  - The CSUM state is present and the frame is 13 bytes.
  - A checksum mismatch raises `frame_err`.
- `ELINK_CHECKSUM_EN` undefined:
  - No CSUM state; EOP directly follows data byte 9, and the frame is 12 bytes.
  - No checksum logic is synthesised.

## Test plan
- Reset, then 20 cycles of idle 8'h7C followed by a frame with payload 76'h0_1234_5678_9ABC_DEF0_123 and a correct trailer. Required: `data_out` equals the payload, `data_valid`=1 one cycle after the EOP, `frame_cnt`=1, `err_cnt`=0.
- Same frame preceded by a 2-bit skew (one extra dibit 2'b01). Required: alignment is found, and the payload and count are identical to the previous test.
- Frame whose EOP is 8'hDD. Required: one `frame_err` pulse, `err_cnt`=1, `data_valid` stays 0. The next valid frame is then received correctly.
- With `ELINK_CHECKSUM_EN` defined, corrupt the checksum byte (XOR with 8'h01). Required: `frame_err` pulse and no load.
- Two back-to-back good frames with `data_ack` held at 0. Required: the first word is held, one `overflow` pulse occurs, `frame_cnt`=1, `err_cnt`=1. Repeat with `data_ack` pulsed in the cycle the second frame loads: the second word is loaded, `data_valid` stays 1, and there is no overflow.
- Assert reset mid-DATA (after byte 4), then send a good frame. Required: no error; `frame_cnt` is 0 after reset and 1 after the good frame. Also preload `frame_cnt`=16'hFFFF by sending 65535 frames or by forcing it; the next good frame must wrap the count to 0.

Source files
------------

// File: rtl/mopshub_elink_deframer.sv
// 2-bit elink receiver: hunts SOP, rebuilds the 76-bit frame word, checks the trailer and holds
// the word in a one-deep valid/ack buffer. Define ELINK_CHECKSUM_EN to add the checksum byte.
module mopshub_elink_deframer #(
    parameter logic [7:0] SOP_CHAR = 8'h3C,
    parameter logic [7:0] EOP_CHAR = 8'hDC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  rx_elink2bit,
    output logic [75:0] data_out,
    output logic        data_valid,
    input  logic        data_ack,
    output logic        frame_err,
    output logic        overflow,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {StHunt, StData, StCsum, StEop} state_e;

    state_e      state_q;
    logic [7:0]  win_q;
    logic [1:0]  dib_cnt_q;
    logic [3:0]  byte_cnt_q;
    logic [75:0] shift_q;
    logic        byte_done;
`ifdef ELINK_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    // The FSM inspects the registered window, so a byte is whole when its 4th dibit is in win_q.
    assign byte_done = (dib_cnt_q == 2'd3);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StHunt;
            win_q      <= '0;
            dib_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
`ifdef ELINK_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            win_q     <= {win_q[5:0], rx_elink2bit};
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            // A same-cycle load below overrides this clear.
            if (data_ack) data_valid <= 1'b0;

            unique case (state_q)
                StHunt: begin
                    if (win_q == SOP_CHAR) begin
                        state_q    <= StData;
                        dib_cnt_q  <= '0;
                        byte_cnt_q <= '0;
`ifdef ELINK_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                    end
                end
                StData: begin
                    dib_cnt_q <= dib_cnt_q + 2'd1;
                    if (byte_done) begin
                        // 80 bits pass through a 76-bit shifter: byte 0's upper nibble falls off.
                        shift_q    <= {shift_q[67:0], win_q};
                        byte_cnt_q <= byte_cnt_q + 4'd1;
`ifdef ELINK_CHECKSUM_EN
                        csum_q     <= csum_q ^ win_q;
                        if (byte_cnt_q == 4'd9) state_q <= StCsum;
`else
                        if (byte_cnt_q == 4'd9) state_q <= StEop;
`endif
                    end
                end
`ifdef ELINK_CHECKSUM_EN
                StCsum: begin
                    dib_cnt_q <= dib_cnt_q + 2'd1;
                    if (byte_done) begin
                        if (win_q == csum_q) begin
                            state_q <= StEop;
                        end else begin
                            frame_err <= 1'b1;
                            err_cnt   <= sat_inc(err_cnt);
                            state_q   <= StHunt;
                        end
                    end
                end
`endif
                StEop: begin
                    dib_cnt_q <= dib_cnt_q + 2'd1;
                    if (byte_done) begin
                        state_q <= StHunt;
                        if (win_q != EOP_CHAR) begin
                            frame_err <= 1'b1;
                            err_cnt   <= sat_inc(err_cnt);
                        end else if (!data_valid || data_ack) begin
                            data_out   <= shift_q;
                            data_valid <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                        end else begin
                            overflow <= 1'b1;
                            err_cnt  <= sat_inc(err_cnt);
                        end
                    end
                end
                default: state_q <= StHunt;
            endcase
        end
    end

endmodule

// File: tb/tb_mopshub_elink_deframer.sv
// Scoreboard bench for mopshub_elink_deframer; follows ELINK_CHECKSUM_EN like the design.
module tb_mopshub_elink_deframer;

    localparam logic [75:0] P1 = 76'h1234_5678_9ABC_DEF0_123;
    localparam logic [75:0] P2 = 76'hFEDC_BA98_7654_3210_ABC;

    logic        clk;
    logic        rst;
    logic [1:0]  rx_elink2bit;
    logic [75:0] data_out;
    logic        data_valid;
    logic        data_ack;
    logic        frame_err;
    logic        overflow;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    mopshub_elink_deframer dut (
        .clk          (clk),
        .rst          (rst),
        .rx_elink2bit (rx_elink2bit),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ack     (data_ack),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          ferr_n   = 0;
    int          ovf_n    = 0;
    bit          mon_en   = 1'b0;
    logic [75:0] sb[$];
    logic [15:0] prev_cnt  = '0;
    logic        prev_ferr = 1'b0;
    logic        prev_ovf  = 1'b0;

    task automatic check(input string tag, input logic [75:0] got, input logic [75:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every frame_cnt step is a buffer load; it must match the oldest expected word.
    always @(posedge clk) begin
        logic [75:0] exp_w;
        #1;
        if (mon_en) begin
            if (frame_cnt != prev_cnt) begin
                check("sb_has_entry", 76'(sb.size() != 0), 76'd1);
                if (sb.size() != 0) begin
                    exp_w = sb.pop_front();
                    check("data_out", data_out, exp_w);
                    check("valid_on_load", 76'(data_valid), 76'd1);
                end
            end
            if (frame_err) begin
                ferr_n++;
                check("frame_err_width", 76'(prev_ferr), 76'd0);
            end
            if (overflow) begin
                ovf_n++;
                check("overflow_width", 76'(prev_ovf), 76'd0);
            end
        end
        prev_cnt  = frame_cnt;
        prev_ferr = frame_err;
        prev_ovf  = overflow;
    end

    task automatic drive(input logic [1:0] d);
        @(negedge clk);
        rx_elink2bit = d;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) drive(b[7-2*k -: 2]);
    endtask

    task automatic send_frame(input logic [75:0] p, input logic [3:0] nib, input logic [7:0] eop,
                              input logic [7:0] cx, input bit ack_at_load);
        logic [79:0] w;
        logic [7:0]  cs;
        w  = {nib, p};
        cs = cx;
        send_byte(8'h3C);
        for (int i = 0; i < 10; i++) begin
            send_byte(w[79-8*i -: 8]);
            cs = cs ^ w[79-8*i -: 8];
        end
`ifdef ELINK_CHECKSUM_EN
        send_byte(cs);
`endif
        send_byte(eop);
        if (ack_at_load) begin
            @(negedge clk);
            data_ack = 1'b1;
            @(negedge clk);
            data_ack = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        check("sb_drained", 76'(sb.size()), 76'd0);
        @(negedge clk);
        mon_en = 1'b0;
        rst    = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        ferr_n = 0;
        ovf_n  = 0;
        mon_en = 1'b1;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        check("ack_clears_valid", 76'(data_valid), 76'd0);
    endtask

    initial begin
        rst          = 1'b0;
        rx_elink2bit = 2'b00;
        data_ack     = 1'b0;
        repeat (3) @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;
        check("rst_data_out", data_out, 76'd0);
        check("rst_valid", 76'(data_valid), 76'd0);
        check("rst_frame_err", 76'(frame_err), 76'd0);
        check("rst_overflow", 76'(overflow), 76'd0);
        check("rst_frame_cnt", 76'(frame_cnt), 76'd0);
        check("rst_err_cnt", 76'(err_cnt), 76'd0);

        // Idle then a clean frame, with one-cycle output latency after the last EOP dibit.
        repeat (5) send_byte(8'h7C);
        sb.push_back(P1);
        send_frame(P1, 4'h0, 8'hDC, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("valid_not_early", 76'(data_valid), 76'd0);
        @(posedge clk);
        #1;
        check("valid_after_eop", 76'(data_valid), 76'd1);
        settle();
        check("t1_frame_cnt", 76'(frame_cnt), 76'd1);
        check("t1_err_cnt", 76'(err_cnt), 76'd0);
        ack_pulse();
        ack_pulse();

        // One-dibit skew ahead of SOP.
        do_reset();
        repeat (5) send_byte(8'h7C);
        drive(2'b01);
        sb.push_back(P1);
        send_frame(P1, 4'h0, 8'hDC, 8'h00, 1'b0);
        settle();
        check("skew_frame_cnt", 76'(frame_cnt), 76'd1);
        check("skew_data_out", data_out, P1);

        // Bad EOP, then a good frame whose ignored upper nibble is non-zero.
        do_reset();
        send_byte(8'h7C);
        send_frame(P1, 4'h0, 8'hDD, 8'h00, 1'b0);
        settle();
        check("bad_eop_pulses", 76'(ferr_n), 76'd1);
        check("bad_eop_err_cnt", 76'(err_cnt), 76'd1);
        check("bad_eop_valid", 76'(data_valid), 76'd0);
        send_byte(8'h7C);
        sb.push_back(P2);
        send_frame(P2, 4'hA, 8'hDC, 8'h00, 1'b0);
        settle();
        check("after_bad_frame_cnt", 76'(frame_cnt), 76'd1);

`ifdef ELINK_CHECKSUM_EN
        do_reset();
        send_byte(8'h7C);
        send_frame(P1, 4'h0, 8'hDC, 8'h01, 1'b0);
        settle();
        check("bad_csum_pulses", 76'(ferr_n), 76'd1);
        check("bad_csum_err_cnt", 76'(err_cnt), 76'd1);
        check("bad_csum_valid", 76'(data_valid), 76'd0);
        check("bad_csum_frame_cnt", 76'(frame_cnt), 76'd0);
`endif

        // Back-to-back frames, no ack: second frame overflows.
        do_reset();
        sb.push_back(P1);
        send_frame(P1, 4'h0, 8'hDC, 8'h00, 1'b0);
        send_frame(P2, 4'h0, 8'hDC, 8'h00, 1'b0);
        settle();
        check("ovf_held_word", data_out, P1);
        check("ovf_valid", 76'(data_valid), 76'd1);
        check("ovf_pulses", 76'(ovf_n), 76'd1);
        check("ovf_frame_cnt", 76'(frame_cnt), 76'd1);
        check("ovf_err_cnt", 76'(err_cnt), 76'd1);

        // Back-to-back with ack in the load cycle of the second frame.
        do_reset();
        sb.push_back(P1);
        send_frame(P1, 4'h0, 8'hDC, 8'h00, 1'b0);
        sb.push_back(P2);
        send_frame(P2, 4'h0, 8'hDC, 8'h00, 1'b1);
        settle();
        check("ackload_word", data_out, P2);
        check("ackload_valid", 76'(data_valid), 76'd1);
        check("ackload_no_ovf", 76'(ovf_n), 76'd0);
        check("ackload_frame_cnt", 76'(frame_cnt), 76'd2);
        check("ackload_err_cnt", 76'(err_cnt), 76'd0);

        // Reset in the middle of DATA, after byte 4.
        do_reset();
        send_byte(8'h3C);
        for (int i = 0; i < 5; i++) send_byte(8'h5A);
        do_reset();
        check("midrst_frame_cnt", 76'(frame_cnt), 76'd0);
        check("midrst_err_cnt", 76'(err_cnt), 76'd0);
        sb.push_back(P2);
        send_frame(P2, 4'h0, 8'hDC, 8'h00, 1'b0);
        settle();
        check("midrst_good_cnt", 76'(frame_cnt), 76'd1);
        check("midrst_no_err", 76'(ferr_n + ovf_n), 76'd0);
        ack_pulse();

        // frame_cnt wraps from 16'hFFFF to 0.
        mon_en = 1'b0;
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        @(negedge clk);
        check("cnt_preload", 76'(frame_cnt), 76'hFFFF);
        mon_en = 1'b1;
        sb.push_back(P1);
        send_frame(P1, 4'h0, 8'hDC, 8'h00, 1'b0);
        settle();
        check("cnt_wrap", 76'(frame_cnt), 76'd0);
        check("sb_final", 76'(sb.size()), 76'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
